// File: rtl/apes_cnt_pkg.sv
// Shared defaults and state encoding for the detector count collector.
package apes_cnt_pkg;

    localparam int NCH_DEF = 52;
    localparam int CW_DEF  = 10;
    localparam int CNT_MAX = (1 << CW_DEF) - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/hit_edge_det.sv
// One-channel hit synchronizer (2 FF) followed by rising-edge detection.
module hit_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic hit_i,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= hit_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/cnt_collect.sv
// Windowed per-channel hit counter with saturation and sticky overflow.
module cnt_collect
    import apes_cnt_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int CW     = CW_DEF,
    parameter int WIN_W  = 26,
    parameter int WINDOW = 50_000_000
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic [NCH-1:0]    hit_in,
    input  logic              cnt_start,
    input  logic              cnt_clr,
    output logic [NCH*CW-1:0] counts,
    output logic [NCH-1:0]    ovf,
    output logic              collect_done,
    output logic              busy
);

    localparam logic [WIN_W-1:0] LAST = WIN_W'(WINDOW - 1);
    localparam logic [CW-1:0]    SAT  = '1;

    state_e           state_q;
    logic [WIN_W-1:0] timer_q;
    logic             busy_q;
    logic             done_q;

    logic [NCH-1:0]   edge_w;
    logic [CW-1:0]    cnt_q [NCH];
    logic [CW-1:0]    cnt_d [NCH];
    logic [NCH-1:0]   ovf_q;
    logic [NCH-1:0]   ovf_d;
    logic             start_w;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        hit_edge_det u_det (
            .clk    (clk50),
            .rst    (rst),
            .hit_i  (hit_in[i]),
            .edge_o (edge_w[i])
        );
        assign counts[CW*i +: CW] = cnt_q[i];
    end

    // clr beats start; start is ignored while a window is running
    assign start_w = cnt_start & ~cnt_clr & (state_q != COLLECT);

    always_ff @(posedge clk50) begin
        if (rst || cnt_clr) begin
            state_q <= IDLE;
            timer_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (cnt_start) begin
                        state_q <= COLLECT;
                        timer_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (timer_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (cnt_clr || start_w) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (state_q == COLLECT && edge_w[i]) begin
                if (cnt_q[i] == SAT) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    assign ovf          = ovf_q;
    assign busy         = busy_q;
    assign collect_done = done_q;

endmodule
